// File: rtl/mem_responder_if.sv
// Request/response bus between a requester (processor side) and a memory
// responder. Both channels use a valid/ready handshake.
interface mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a programmable number of wait states.
// One transaction in flight at a time: IDLE accepts, WAIT models slow memory,
// RESP holds the response until the requester takes it.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 200,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_if.slave       bus,
  output logic [1:0] cur
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Counter start value; unused when there are no wait states.
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              req_ready_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              do_access;
  logic              do_write;
  logic              in_range;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign accept = bus.req_valid & req_ready_reg;

  // Access operands: straight from the bus when the access happens on the
  // accept edge (no wait states), otherwise from the latched request.
  always_comb begin
    acc_we    = we_reg;
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    if (state_reg == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
  end

  assign in_range  = (32'(acc_addr) < 32'(DEPTH));
  assign do_access = ((state_reg == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == 4'd0));
  // Held reset blocks writes so an interrupted write never lands.
  assign do_write  = do_access & acc_we & in_range & rst;

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  // Transaction FSM with registered handshake outputs and response fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg        <= bus.req_we;
            addr_reg      <= bus.req_addr;
            wdata_reg     <= bus.req_wdata;
            req_ready_reg <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              rsp_rdata_reg <= (!acc_we && in_range) ? mem[acc_addr] : '0;
              rsp_err_reg   <= !in_range;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else begin
              cnt_reg   <= WAIT_INIT;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            rsp_rdata_reg <= (!acc_we && in_range) ? mem[acc_addr] : '0;
            rsp_err_reg   <= !in_range;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign cur           = state_reg;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed 16-bit memory responder for the processor's data/instruction bus.
- Sits on the slave side of the processor's load/store/fetch requests and answers them through a valid/ready request channel and a valid/ready response channel.
- Has a programmable wait-state count so the bench can model slow memory.
- Exposes its FSM state on a 2-bit debug port, in the same way the processor exposes its own state.

Parameters:
ADDR_W, 8, request address width in words
DATA_W, 16, data word width
DEPTH, 200, number of implemented words; addresses >= DEPTH are out of range
WAIT_CYCLES, 2, wait-state cycles between request accept and memory access (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  DATA_W  read data; 0 for writes and errors
rsp_err  output  1  out-of-range address
cur  output  2  FSM state: 00 IDLE, 01 WAIT, 10 RESP

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cur=00, wait counter=0.
  - Memory array contents are not reset. Reads of never-written words return X in simulation.
- Handshake:
  - A request transfers on a rising edge with req_valid&req_ready.
  - A response transfers on a rising edge with rsp_valid&rsp_ready.
  - Request signals are don't-care when req_valid=0.
- Once rsp_valid is asserted, rsp_valid, rsp_rdata and rsp_err hold stable until the response transfers.
- IDLE:
  - req_ready=1.
  - On accept, latch we, addr and wdata.
  - If WAIT_CYCLES==0, perform the access on the same edge and go to RESP. Otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter==0: perform the access, register the response fields, go to RESP. Otherwise decrement the counter.
  - WAIT therefore lasts exactly WAIT_CYCLES cycles.
- Access rules:
  - Write in range: mem[addr]<=wdata; rsp_rdata=0; rsp_err=0.
  - Read in range: rsp_rdata=mem[addr]; rsp_err=0.
  - addr>=DEPTH: no memory update; rsp_rdata=0; rsp_err=1.
- RESP:
  - req_ready=0, rsp_valid=1.
  - On the response transfer, go to IDLE, and on that same edge clear rsp_valid, rsp_rdata and rsp_err.
- Latency:
  - A request accepted at edge T0 gives rsp_valid high after edge T0+WAIT_CYCLES.
  - The earliest response transfer is edge T0+WAIT_CYCLES+1.
  - The next request can be accepted one edge after the response transfer. Minimum period is WAIT_CYCLES+2 cycles per transaction.
- Simultaneous and boundary cases:
  - req_valid while not IDLE is ignored (req_ready=0). The requester holds it.
  - rsp_ready high before rsp_valid is legal; the transfer then occurs on the first edge with rsp_valid=1.
  - Read-after-write to the same address returns the new data: the write is committed before the next request can be accepted.
  - Address DEPTH-1 is in range; address DEPTH is an error.
  - Reset during WAIT discards a pending write; memory is unchanged.
  - Reset during RESP drops the response.
- The block makes no combinational path from any input to req_ready or rsp_valid; both are functions of state only.

Test Plan:
- Reset, then write 16'hBEEF to addr 5 and read addr 5 (WAIT_CYCLES=2) -> write response rsp_err=0, rsp_rdata=0; read response rsp_rdata=16'hBEEF; rsp_valid rises 2 edges after each accept; cur steps 00->01->01->10->00.
- WAIT_CYCLES=0 instance: read addr 0 after writing 16'h1234 -> rsp_valid high immediately after the accept edge; cur never shows 01.
- Read addr 200 and write 16'hFFFF to addr 200 (DEPTH=200); then read addr 199 after writing 16'h0A0A there -> both out-of-range accesses give rsp_err=1 and rsp_rdata=0; addr 199 reads 16'h0A0A with rsp_err=0.
- Hold rsp_ready=0 for 5 cycles during RESP while toggling req_valid -> rsp_valid and rsp_rdata stay stable, req_ready=0 throughout, no second request accepted; response transfers on the first edge with rsp_ready=1.
- Write 16'h5555 to addr 7, then write 16'hAAAA to addr 7 and pull rst low during its WAIT; release and read addr 7 -> outputs clear asynchronously, cur=00, read returns 16'h5555.
- Back-to-back reads with req_valid and rsp_ready held at 1 -> one transaction every WAIT_CYCLES+2 cycles (4 cycles for WAIT_CYCLES=2); no lost or duplicated responses.
